mem_stage: RTL and testbench

- Memory-access pipeline stage sitting directly downstream of the execute stage; consumes the EXE/MEM register contents.
- Drives the data-memory request handshake, generating byte enables and lane-shifted store data, and sign/zero-extends load data.
- Stalls the pipeline while a memory access is outstanding.
- Provides the MEM forwarding value back to execute and registers the MEM/WB pipeline outputs.

---
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory handshake, lane-shifts stores and extends loads.
// MEM/WB results land one cycle after the completing cycle; mem_stall holds upstream while an access is outstanding.
module mem_stage #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_ALUout,
  input  logic [31:0] EXE_PCtoReg,
  input  logic [31:0] EXE_rs2data,
  input  logic [4:0]  EXE_rdaddr,
  input  logic [2:0]  EXE_Funct3,
  input  logic        EXE_rdsrc,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_RegWrite,
  output logic        DM_req,
  output logic [3:0]  DM_wen,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_wdata,
  input  logic [31:0] DM_rdata,
  input  logic        DM_ready,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] Forward_Memrddata,
  output logic [31:0] MEM_rddata,
  output logic [4:0]  MEM_rdaddr,
  output logic        MEM_RegWrite
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rddata_q, rddata_d;
  logic [4:0]    rdaddr_q, rdaddr_d;
  logic          regwrite_q, regwrite_d;

  logic        access, capture, aborting, timeout;
  logic [3:0]  wen_raw;
  logic [31:0] result, rd_shift, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign access  = EXE_MemRead | EXE_MemWrite;
  assign result  = EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout;
  assign DM_addr = {EXE_ALUout[31:2], 2'b00};
  assign Forward_Memrddata = result;
  assign mem_err = (state_q == ABORT);

  // The issue cycle counts as the first stall cycle, so WAIT_LIMIT bounds total stall cycles.
  assign timeout = (WAIT_LIMIT != 0) && ((int'(cnt_q) + 2) >= WAIT_LIMIT);

  always_comb begin
    wen_raw  = 4'b1111;
    DM_wdata = EXE_rs2data;
    case (EXE_Funct3)
      3'b000: begin
        wen_raw  = 4'b0001 << EXE_ALUout[1:0];
        DM_wdata = {4{EXE_rs2data[7:0]}};
      end
      3'b001: begin
        wen_raw  = 4'b0011 << {EXE_ALUout[1], 1'b0};
        DM_wdata = {2{EXE_rs2data[15:0]}};
      end
      default: ;
    endcase
  end

  assign DM_wen = EXE_MemWrite ? wen_raw : 4'b0000;

  assign rd_shift = DM_rdata >> {EXE_ALUout[1:0], 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = EXE_ALUout[1] ? DM_rdata[31:16] : DM_rdata[15:0];

  always_comb begin
    case (EXE_Funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'b0, ld_byte};
      3'b101:  load_ext = {16'b0, ld_half};
      default: load_ext = DM_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    DM_req    = 1'b0;
    mem_stall = 1'b0;
    capture   = 1'b0;
    aborting  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (access) begin
          DM_req = 1'b1;
          if (DM_ready) begin
            capture = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_d   = WAIT;
          end
        end else begin
          capture = 1'b1;
        end
      end
      WAIT: begin
        DM_req = 1'b1;
        if (DM_ready) begin
          capture = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          mem_stall = 1'b1;
          if (timeout) state_d = ABORT;
          else if (WAIT_LIMIT != 0) cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        capture  = 1'b1;
        aborting = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end
    endcase
    if (!rst) begin
      DM_req    = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // Stall cycles load a bubble so a held instruction never writes back twice.
  always_comb begin
    rddata_d   = 32'b0;
    rdaddr_d   = 5'b0;
    regwrite_d = 1'b0;
    if (capture) begin
      rdaddr_d = EXE_rdaddr;
      if (aborting) begin
        rddata_d   = 32'b0;
        regwrite_d = EXE_RegWrite & ~EXE_MemWrite;
      end else begin
        rddata_d   = EXE_MemtoReg ? load_ext : result;
        regwrite_d = EXE_RegWrite;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rddata_q   <= 32'b0;
      rdaddr_q   <= 5'b0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rddata_q   <= rddata_d;
      rdaddr_q   <= rdaddr_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign MEM_rddata   = rddata_q;
  assign MEM_rdaddr   = rdaddr_q;
  assign MEM_RegWrite = regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with WAIT_LIMIT=4; every expected value is hand-computed.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXE_ALUout, EXE_PCtoReg, EXE_rs2data;
  logic [4:0]  EXE_rdaddr;
  logic [2:0]  EXE_Funct3;
  logic        EXE_rdsrc, EXE_MemRead, EXE_MemWrite, EXE_MemtoReg, EXE_RegWrite;
  logic        DM_req;
  logic [3:0]  DM_wen;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic        DM_ready, mem_stall, mem_err;
  logic [31:0] Forward_Memrddata, MEM_rddata;
  logic [4:0]  MEM_rdaddr;
  logic        MEM_RegWrite;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .EXE_ALUout(EXE_ALUout), .EXE_PCtoReg(EXE_PCtoReg), .EXE_rs2data(EXE_rs2data),
    .EXE_rdaddr(EXE_rdaddr), .EXE_Funct3(EXE_Funct3), .EXE_rdsrc(EXE_rdsrc),
    .EXE_MemRead(EXE_MemRead), .EXE_MemWrite(EXE_MemWrite),
    .EXE_MemtoReg(EXE_MemtoReg), .EXE_RegWrite(EXE_RegWrite),
    .DM_req(DM_req), .DM_wen(DM_wen), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
    .DM_rdata(DM_rdata), .DM_ready(DM_ready), .mem_stall(mem_stall), .mem_err(mem_err),
    .Forward_Memrddata(Forward_Memrddata), .MEM_rddata(MEM_rddata),
    .MEM_rdaddr(MEM_rdaddr), .MEM_RegWrite(MEM_RegWrite)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    EXE_ALUout = 0; EXE_PCtoReg = 0; EXE_rs2data = 0; EXE_rdaddr = 0; EXE_Funct3 = 0;
    EXE_rdsrc = 0; EXE_MemRead = 0; EXE_MemWrite = 0; EXE_MemtoReg = 0; EXE_RegWrite = 0;
    DM_rdata = 0; DM_ready = 0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    clr();
    EXE_ALUout = addr; EXE_Funct3 = f3; EXE_rdaddr = rd;
    EXE_MemRead = 1; EXE_MemtoReg = 1; EXE_RegWrite = 1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    EXE_MemRead = 1; EXE_ALUout = 32'h40;
    #1;
    chk("rst_req", {31'b0, DM_req}, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    step(); step();
    chk("rst_rddata", MEM_rddata, 32'h0);
    chk("rst_rdaddr", {27'b0, MEM_rdaddr}, 32'h0);
    chk("rst_regwrite", {31'b0, MEM_RegWrite}, 32'h0);
    chk("rst_err", {31'b0, mem_err}, 32'h0);
    clr();
    rst = 1'b1;
    step();

    // ALU pass-through
    EXE_ALUout = 32'h1234_5678; EXE_rdaddr = 5; EXE_RegWrite = 1;
    #1;
    chk("alu_stall", {31'b0, mem_stall}, 32'h0);
    chk("alu_req", {31'b0, DM_req}, 32'h0);
    chk("alu_fwd", Forward_Memrddata, 32'h1234_5678);
    step();
    chk("alu_rddata", MEM_rddata, 32'h1234_5678);
    chk("alu_rdaddr", {27'b0, MEM_rdaddr}, 32'd5);
    chk("alu_regwrite", {31'b0, MEM_RegWrite}, 32'h1);

    // Loads completing in the issue cycle
    load(32'h0000_1003, 3'b000, 7);
    DM_rdata = 32'h80FF_FFFF; DM_ready = 1;
    #1;
    chk("lb_addr", DM_addr, 32'h0000_1000);
    chk("lb_wen", {28'b0, DM_wen}, 32'h0);
    chk("lb_req", {31'b0, DM_req}, 32'h1);
    chk("lb_stall", {31'b0, mem_stall}, 32'h0);
    step();
    chk("lb_rddata", MEM_rddata, 32'hFFFF_FF80);
    chk("lb_rdaddr", {27'b0, MEM_rdaddr}, 32'd7);
    EXE_Funct3 = 3'b100;
    step();
    chk("lbu_rddata", MEM_rddata, 32'h0000_0080);
    EXE_ALUout = 32'h0000_1002; EXE_Funct3 = 3'b001; DM_rdata = 32'h80FF_1234;
    step();
    chk("lh_rddata", MEM_rddata, 32'hFFFF_80FF);
    EXE_Funct3 = 3'b101;
    step();
    chk("lhu_rddata", MEM_rddata, 32'h0000_80FF);
    EXE_ALUout = 32'h0000_1001; EXE_Funct3 = 3'b011;
    step();
    chk("lw_odd_f3", MEM_rddata, 32'h80FF_1234);

    // SH at offset 2 with ready after 3 stall cycles
    clr();
    EXE_ALUout = 32'h0000_2002; EXE_rs2data = 32'hAAAA_BEEF; EXE_Funct3 = 3'b001;
    EXE_MemWrite = 1;
    #1;
    chk("sh_wen", {28'b0, DM_wen}, 32'hC);
    chk("sh_wdata", DM_wdata, 32'hBEEF_BEEF);
    chk("sh_stall0", {31'b0, mem_stall}, 32'h1);
    step();
    chk("sh_stall1", {31'b0, mem_stall}, 32'h1);
    chk("sh_wdata1", DM_wdata, 32'hBEEF_BEEF);
    chk("sh_req1", {31'b0, DM_req}, 32'h1);
    chk("sh_rw1", {31'b0, MEM_RegWrite}, 32'h0);
    step();
    chk("sh_stall2", {31'b0, mem_stall}, 32'h1);
    chk("sh_wen2", {28'b0, DM_wen}, 32'hC);
    DM_ready = 1;
    #1;
    chk("sh_stall3", {31'b0, mem_stall}, 32'h0);
    chk("sh_req3", {31'b0, DM_req}, 32'h1);
    step();
    chk("sh_rw_done", {31'b0, MEM_RegWrite}, 32'h0);

    // SB with MemRead and MemWrite both set behaves as a store
    clr();
    EXE_ALUout = 32'h0000_2001; EXE_rs2data = 32'h1122_3344; EXE_Funct3 = 3'b000;
    EXE_MemWrite = 1; EXE_MemRead = 1; DM_ready = 1;
    #1;
    chk("sb_wen", {28'b0, DM_wen}, 32'h2);
    chk("sb_wdata", DM_wdata, 32'h4444_4444);
    EXE_Funct3 = 3'b010; EXE_MemRead = 0;
    #1;
    chk("sw_wen", {28'b0, DM_wen}, 32'hF);
    chk("sw_wdata", DM_wdata, 32'h1122_3344);
    step();

    // LW timeout: 4 stall cycles then ABORT
    load(32'h0000_3000, 3'b010, 9);
    #1;
    chk("to_stall0", {31'b0, mem_stall}, 32'h1);
    step();
    chk("to_stall1", {31'b0, mem_stall}, 32'h1);
    step();
    chk("to_stall2", {31'b0, mem_stall}, 32'h1);
    chk("to_rw2", {31'b0, MEM_RegWrite}, 32'h0);
    step();
    chk("to_stall3", {31'b0, mem_stall}, 32'h1);
    chk("to_err3", {31'b0, mem_err}, 32'h0);
    step();
    chk("abort_err", {31'b0, mem_err}, 32'h1);
    chk("abort_req", {31'b0, DM_req}, 32'h0);
    chk("abort_stall", {31'b0, mem_stall}, 32'h0);
    step();
    clr();
    #1;
    chk("abort_rddata", MEM_rddata, 32'h0);
    chk("abort_rdaddr", {27'b0, MEM_rdaddr}, 32'd9);
    chk("abort_rw", {31'b0, MEM_RegWrite}, 32'h1);
    chk("abort_err_clr", {31'b0, mem_err}, 32'h0);
    step();

    // Reset during WAIT, then a late ready
    load(32'h0000_4000, 3'b010, 11);
    step();
    chk("rw_in_wait", {31'b0, mem_stall}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rw_req_rst", {31'b0, DM_req}, 32'h0);
    chk("rw_stall_rst", {31'b0, mem_stall}, 32'h0);
    step();
    rst = 1'b1;
    clr();
    DM_ready = 1; DM_rdata = 32'hCAFE_F00D;
    #1;
    chk("rw_req", {31'b0, DM_req}, 32'h0);
    chk("rw_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_rddata_rst", MEM_rddata, 32'h0);
    step();
    DM_ready = 0;
    chk("rw_rddata", MEM_rddata, 32'h0);
    chk("rw_rdaddr", {27'b0, MEM_rdaddr}, 32'h0);
    chk("rw_rw", {31'b0, MEM_RegWrite}, 32'h0);

    // JAL link value
    EXE_rdsrc = 1; EXE_PCtoReg = 32'h0000_0104; EXE_ALUout = 32'h0000_DEAD;
    EXE_rdaddr = 1; EXE_RegWrite = 1;
    #1;
    chk("jal_fwd", Forward_Memrddata, 32'h0000_0104);
    step();
    chk("jal_rddata", MEM_rddata, 32'h0000_0104);
    chk("jal_rdaddr", {27'b0, MEM_rdaddr}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
